// File: rtl/ysyx_23060240_ifu.sv
// Instruction fetch unit: holds the PC, issues one imem fetch at a time and
// hands {pc, inst, err} to decode, honouring redirects from branch resolution.
module ysyx_23060240_ifu #(
    parameter int unsigned          XLEN     = 32,
    parameter logic [XLEN-1:0]      RESET_PC = 32'h8000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            imem_rsp_err,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [31:0]     out_inst,
    output logic            out_err
);

    localparam int unsigned INST_W = 32;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2,
        S_HOLD = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   out_pc_q, out_pc_d;
    logic [INST_W-1:0] out_inst_q, out_inst_d;
    logic              out_err_q, out_err_d;

    logic aligned_c;
    logic req_fire_c;

    // Handshake outputs are combinational; a redirect suppresses delivery in the same cycle.
    assign aligned_c      = (pc_q[1:0] == 2'b00);
    assign imem_req_valid = rst_n && (state_q == S_REQ) && aligned_c;
    assign imem_req_addr  = pc_q;
    assign req_fire_c     = imem_req_valid && imem_req_ready;
    assign out_valid      = (state_q == S_HOLD) && !redirect_valid;
    assign out_pc         = out_pc_q;
    assign out_inst       = out_inst_q;
    assign out_err        = out_err_q;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        out_pc_d   = out_pc_q;
        out_inst_d = out_inst_q;
        out_err_d  = out_err_q;

        if (redirect_valid) begin
            pc_d = redirect_pc;
        end

        unique case (state_q)
            S_REQ: begin
                if (req_fire_c) begin
                    state_d = redirect_valid ? S_DROP : S_WAIT;
                end else if (!aligned_c && !redirect_valid) begin
                    // Misaligned PC never reaches imem; deliver a fault instead.
                    state_d    = S_HOLD;
                    out_pc_d   = pc_q;
                    out_inst_d = '0;
                    out_err_d  = 1'b1;
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    state_d = imem_rsp_valid ? S_REQ : S_DROP;
                end else if (imem_rsp_valid) begin
                    state_d    = S_HOLD;
                    out_pc_d   = pc_q;
                    out_inst_d = imem_rsp_data;
                    out_err_d  = imem_rsp_err;
                end
            end
            S_DROP: begin
                if (imem_rsp_valid) begin
                    state_d = S_REQ;
                end
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    state_d = S_REQ;
                end else if (out_ready) begin
                    state_d = S_REQ;
                    pc_d    = pc_q + XLEN'(4);
                end
            end
            default: state_d = S_REQ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_REQ;
            pc_q       <= RESET_PC;
            out_pc_q   <= '0;
            out_inst_q <= '0;
            out_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            out_pc_q   <= out_pc_d;
            out_inst_q <= out_inst_d;
            out_err_q  <= out_err_d;
        end
    end

endmodule

// File: tb/tb_ysyx_23060240_ifu.sv
// Directed cycle-by-cycle bench for the IFU: table of per-cycle inputs and
// expected outputs, plus hand-written reset sequences.
module tb_ysyx_23060240_ifu;

    logic        clk;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_err;

    ysyx_23060240_ifu dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .imem_rsp_err   (imem_rsp_err),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_inst       (out_inst),
        .out_err        (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rv;
        logic [31:0] rpc;
        logic        rdy;
        logic        rspv;
        logic [31:0] rdata;
        logic        rerr;
        logic        ordy;
        logic        e_rqv;
        logic [31:0] e_addr;
        logic        e_ov;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
        logic        e_err;
    } vec_t;

    vec_t vecs[$];
    int   n_vec;
    int   n_bad;

    task automatic add(input logic rv, input logic [31:0] rpc, input logic rdy,
                       input logic rspv, input logic [31:0] rdata, input logic rerr,
                       input logic ordy, input logic e_rqv, input logic [31:0] e_addr,
                       input logic e_ov, input logic [31:0] e_pc, input logic [31:0] e_inst,
                       input logic e_err);
        vec_t v;
        v.rv = rv; v.rpc = rpc; v.rdy = rdy; v.rspv = rspv; v.rdata = rdata;
        v.rerr = rerr; v.ordy = ordy; v.e_rqv = e_rqv; v.e_addr = e_addr;
        v.e_ov = e_ov; v.e_pc = e_pc; v.e_inst = e_inst; v.e_err = e_err;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        redirect_valid = v.rv;
        redirect_pc    = v.rpc;
        imem_req_ready = v.rdy;
        imem_rsp_valid = v.rspv;
        imem_rsp_data  = v.rdata;
        imem_rsp_err   = v.rerr;
        out_ready      = v.ordy;
    endtask

    task automatic idle();
        redirect_valid = 1'b0; redirect_pc = '0; imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0; imem_rsp_data = '0; imem_rsp_err = 1'b0; out_ready = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        idle();
        rst_n = 1'b0;

        //   rv rpc           rdy rspv rdata         rerr ordy | rqv addr         ov pc            inst          err
        add(0, 32'h0,         1, 0, 32'h0,         0, 0,   1, 32'h8000_0000, 0, 32'h0,         32'h0,         0);
        add(0, 32'h0,         0, 1, 32'h0000_0013, 0, 0,   0, 32'h0,         0, 32'h0,         32'h0,         0);
        add(0, 32'h0,         0, 0, 32'h0,         0, 1,   0, 32'h0,         1, 32'h8000_0000, 32'h0000_0013, 0);
        add(0, 32'h0,         1, 0, 32'h0,         0, 0,   1, 32'h8000_0004, 0, 32'h0,         32'h0,         0);
        add(0, 32'h0,         0, 1, 32'h0010_0093, 0, 0,   0, 32'h0,         0, 32'h0,         32'h0,         0);
        for (int i = 0; i < 5; i++)
            add(0, 32'h0,     0, 0, 32'h0,         0, 0,   0, 32'h0,         1, 32'h8000_0004, 32'h0010_0093, 0);
        add(0, 32'h0,         0, 0, 32'h0,         0, 1,   0, 32'h0,         1, 32'h8000_0004, 32'h0010_0093, 0);
        // redirect on the accept cycle; late response must be dropped
        add(1, 32'h8000_0100, 1, 0, 32'h0,         0, 0,   1, 32'h8000_0008, 0, 32'h0,         32'h0,         0);
        add(0, 32'h0,         0, 0, 32'h0,         0, 1,   0, 32'h0,         0, 32'h0,         32'h0,         0);
        add(0, 32'h0,         0, 0, 32'h0,         0, 1,   0, 32'h0,         0, 32'h0,         32'h0,         0);
        add(0, 32'h0,         0, 1, 32'hDEAD_BEEF, 0, 1,   0, 32'h0,         0, 32'h0,         32'h0,         0);
        add(0, 32'h0,         0, 0, 32'h0,         0, 1,   1, 32'h8000_0100, 0, 32'h0,         32'h0,         0);
        add(0, 32'h0,         1, 0, 32'h0,         0, 1,   1, 32'h8000_0100, 0, 32'h0,         32'h0,         0);
        add(0, 32'h0,         0, 1, 32'h0000_0513, 0, 0,   0, 32'h0,         0, 32'h0,         32'h0,         0);
        // redirect in HOLD with out_ready: no transfer
        add(1, 32'h8000_0040, 0, 0, 32'h0,         0, 1,   0, 32'h0,         0, 32'h0,         32'h0,         0);
        add(0, 32'h0,         1, 0, 32'h0,         0, 0,   1, 32'h8000_0040, 0, 32'h0,         32'h0,         0);
        add(0, 32'h0,         0, 1, 32'h0000_0593, 0, 0,   0, 32'h0,         0, 32'h0,         32'h0,         0);
        add(1, 32'h8000_0042, 0, 0, 32'h0,         0, 0,   0, 32'h0,         0, 32'h0,         32'h0,         0);
        // misaligned PC: no request, fault delivered
        add(0, 32'h0,         1, 0, 32'h0,         0, 0,   0, 32'h0,         0, 32'h0,         32'h0,         0);
        add(0, 32'h0,         0, 0, 32'h0,         0, 0,   0, 32'h0,         1, 32'h8000_0042, 32'h0,         1);
        add(1, 32'h8000_0010, 0, 0, 32'h0,         0, 1,   0, 32'h0,         0, 32'h0,         32'h0,         0);
        // access fault on fetch
        add(0, 32'h0,         1, 0, 32'h0,         0, 0,   1, 32'h8000_0010, 0, 32'h0,         32'h0,         0);
        add(0, 32'h0,         0, 1, 32'h0,         1, 0,   0, 32'h0,         0, 32'h0,         32'h0,         0);
        add(0, 32'h0,         0, 0, 32'h0,         0, 1,   0, 32'h0,         1, 32'h8000_0010, 32'h0,         1);
        // redirect with response in WAIT, then redirects in REQ and DROP
        add(0, 32'h0,         1, 0, 32'h0,         0, 0,   1, 32'h8000_0014, 0, 32'h0,         32'h0,         0);
        add(1, 32'h8000_0200, 0, 1, 32'h1111_1111, 0, 0,   0, 32'h0,         0, 32'h0,         32'h0,         0);
        add(1, 32'h8000_0300, 0, 0, 32'h0,         0, 0,   1, 32'h8000_0200, 0, 32'h0,         32'h0,         0);
        add(0, 32'h0,         1, 0, 32'h0,         0, 0,   1, 32'h8000_0300, 0, 32'h0,         32'h0,         0);
        add(1, 32'h8000_0400, 0, 0, 32'h0,         0, 0,   0, 32'h0,         0, 32'h0,         32'h0,         0);
        add(1, 32'h8000_0500, 0, 0, 32'h0,         0, 0,   0, 32'h0,         0, 32'h0,         32'h0,         0);
        add(1, 32'h8000_0600, 0, 1, 32'h7777_7777, 0, 0,   0, 32'h0,         0, 32'h0,         32'h0,         0);
        add(0, 32'h0,         1, 0, 32'h0,         0, 0,   1, 32'h8000_0600, 0, 32'h0,         32'h0,         0);
        add(0, 32'h0,         0, 1, 32'h2222_2222, 0, 0,   0, 32'h0,         0, 32'h0,         32'h0,         0);
        add(0, 32'h0,         0, 0, 32'h0,         0, 1,   0, 32'h0,         1, 32'h8000_0600, 32'h2222_2222, 0);
        // stray response in REQ is ignored
        add(0, 32'h0,         0, 1, 32'h3333_3333, 0, 0,   1, 32'h8000_0604, 0, 32'h0,         32'h0,         0);
        add(0, 32'h0,         1, 0, 32'h0,         0, 0,   1, 32'h8000_0604, 0, 32'h0,         32'h0,         0);
        add(0, 32'h0,         0, 1, 32'h4444_4444, 0, 0,   0, 32'h0,         0, 32'h0,         32'h0,         0);
        add(0, 32'h0,         0, 0, 32'h0,         0, 1,   0, 32'h0,         1, 32'h8000_0604, 32'h4444_4444, 0);
        // PC wrap at the top of the address space
        add(1, 32'hFFFF_FFFC, 0, 0, 32'h0,         0, 0,   1, 32'h8000_0608, 0, 32'h0,         32'h0,         0);
        add(0, 32'h0,         1, 0, 32'h0,         0, 0,   1, 32'hFFFF_FFFC, 0, 32'h0,         32'h0,         0);
        add(0, 32'h0,         0, 1, 32'h5555_5555, 0, 0,   0, 32'h0,         0, 32'h0,         32'h0,         0);
        add(0, 32'h0,         0, 0, 32'h0,         0, 1,   0, 32'h0,         1, 32'hFFFF_FFFC, 32'h5555_5555, 0);
        add(0, 32'h0,         0, 0, 32'h0,         0, 0,   1, 32'h0000_0000, 0, 32'h0,         32'h0,         0);

        // reset state
        repeat (2) @(negedge clk);
        #1;
        n_vec++;
        chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_inst", out_inst, 32'h0);
        chk("rst_out_err", 32'(out_err), 32'h0);
        chk("rst_pc", imem_req_addr, 32'h8000_0000);

        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            n_vec++;
            chk($sformatf("v%0d_req_valid", i), 32'(imem_req_valid), 32'(vecs[i].e_rqv));
            if (vecs[i].e_rqv) chk($sformatf("v%0d_req_addr", i), imem_req_addr, vecs[i].e_addr);
            chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
            if (vecs[i].e_ov) begin
                chk($sformatf("v%0d_out_pc", i), out_pc, vecs[i].e_pc);
                chk($sformatf("v%0d_out_inst", i), out_inst, vecs[i].e_inst);
                chk($sformatf("v%0d_out_err", i), 32'(out_err), 32'(vecs[i].e_err));
            end
        end

        // reset asserted mid-transaction, then a clean fetch after release
        @(negedge clk);
        idle();
        imem_req_ready = 1'b1;
        @(negedge clk);
        idle();
        rst_n = 1'b0;
        #1;
        n_vec++;
        chk("midrst_req_valid", 32'(imem_req_valid), 32'h0);
        chk("midrst_out_valid", 32'(out_valid), 32'h0);
        chk("midrst_out_inst", out_inst, 32'h0);
        chk("midrst_out_err", 32'(out_err), 32'h0);
        chk("midrst_pc", imem_req_addr, 32'h8000_0000);

        @(negedge clk);
        rst_n = 1'b1;
        imem_req_ready = 1'b1;
        #1;
        n_vec++;
        chk("post_rst_req_valid", 32'(imem_req_valid), 32'h1);
        chk("post_rst_req_addr", imem_req_addr, 32'h8000_0000);

        @(negedge clk);
        idle();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0000_0013;
        @(negedge clk);
        idle();
        #1;
        n_vec++;
        chk("post_rst_out_valid", 32'(out_valid), 32'h1);
        chk("post_rst_out_pc", out_pc, 32'h8000_0000);
        chk("post_rst_out_inst", out_inst, 32'h0000_0013);
        chk("post_rst_out_err", 32'(out_err), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
